column_distance_buffer: RTL and testbench

Double-buffered per-column ray store between the raycasting engine (writer) and the per-pixel wall lookup stage (reader). The raycaster deposits one Q8.8 wall distance and texture u-coordinate per screen column into a back bank through a valid/ready handshake. The VGA-side pipeline reads the front bank by `screen_x` at pixel rate. Banks swap only at the start of vertical blank, so a frame never shows a partially updated scene.

---
 rtl/column_distance_buffer.sv | 71 +++++++
 tb/tb_column_distance_buffer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/column_distance_buffer.sv
// column_distance_buffer: double-buffered per-column distance/uv store, banks swap at vblank; `COLUMN_BUFFER_STATS_EN builds frame_count/dropped_writes
module column_distance_buffer #(
  parameter int SCREEN_WIDTH = 640,
  parameter int TEXTURE_SIZE = 64,
  localparam int UW = $clog2(TEXTURE_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [9:0]    wr_column,
  input  logic [15:0]   wr_distance,
  input  logic [UW-1:0] wr_uv_x,
  input  logic          frame_done,
  input  logic          vblank_start,
  input  logic [9:0]    screen_x,
  output logic [15:0]   rd_distance,
  output logic [UW-1:0] rd_uv_x,
  output logic          swap_pending,
  output logic          wr_error,
  output logic [15:0]   frame_count,
  output logic [15:0]   dropped_writes
);
  typedef enum logic {FILL, PENDING} state_t;
  localparam logic [9:0] LIMIT = 10'(SCREEN_WIDTH);
  state_t state, state_nx;
  logic front_sel, front_valid, rd_ok, wr_fire, wr_in, swap;
  logic [15+UW:0] mem [2][SCREEN_WIDTH];
  logic [15+UW:0] rd_q;
  assign wr_ready = state == FILL && !reset;
  assign wr_fire = wr_valid && wr_ready;
  assign wr_in = wr_column < LIMIT;
  assign swap = vblank_start && (state == PENDING || frame_done);
  assign swap_pending = state == PENDING;
  assign rd_distance = rd_ok ? rd_q[15+UW:UW] : 16'hFFFF;
  assign rd_uv_x = rd_ok ? rd_q[UW-1:0] : '0;
  always_comb state_nx = state == FILL ? ((frame_done && !vblank_start) ? PENDING : FILL) : (vblank_start ? FILL : PENDING);
  always_ff @(posedge clk)
    if (reset) begin
      state <= FILL;
      front_sel <= 1'b0;
      front_valid <= 1'b0;
      wr_error <= 1'b0;
      rd_ok <= 1'b0;
    end else begin
      state <= state_nx;
      if (swap) begin
        front_sel <= !front_sel;
        front_valid <= 1'b1;
      end
      if (wr_fire && !wr_in) wr_error <= 1'b1;
      rd_ok <= front_valid && screen_x < LIMIT;
    end
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in) mem[!front_sel][wr_column] <= {(wr_distance == 16'd0 ? 16'h0001 : wr_distance), wr_uv_x};
    rd_q <= mem[front_sel][screen_x < LIMIT ? screen_x : 10'd0];
  end
`ifdef COLUMN_BUFFER_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      frame_count <= '0;
      dropped_writes <= '0;
    end else begin
      if (swap && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      if (wr_fire && !wr_in && dropped_writes != 16'hFFFF) dropped_writes <= dropped_writes + 16'd1;
    end
`else
  assign frame_count = '0;
  assign dropped_writes = '0;
`endif
endmodule

// File: tb/tb_column_distance_buffer.sv
// tb_column_distance_buffer: table vectors plus randomized run against a two-bank exchange model
module tb_column_distance_buffer;
  localparam int UW = 6;
  localparam int SW = 640;
  logic clk = 1'b0;
  logic reset, wr_valid, wr_ready, frame_done, vblank_start, swap_pending, wr_error;
  logic [9:0] wr_column, screen_x;
  logic [15:0] wr_distance, rd_distance, frame_count, dropped_writes;
  logic [UW-1:0] wr_uv_x, rd_uv_x;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {bit known; logic [15:0] d; logic [UW-1:0] u;} ent_t;
  ent_t disp [SW];
  ent_t hid [SW];
  bit m_valid, m_pend, m_err;
  logic [15:0] m_fc, m_dw;
  typedef struct {
    bit r; bit wv; logic [9:0] col; logic [15:0] d; logic [UW-1:0] u; bit fd; bit vb; logic [9:0] sx;
    logic [15:0] ed; logic [UW-1:0] eu; bit er; bit ep;
  } vec_t;
  vec_t tbl [17];
  always #5 clk = !clk;
  column_distance_buffer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_column(wr_column),
    .wr_distance(wr_distance), .wr_uv_x(wr_uv_x), .frame_done(frame_done), .vblank_start(vblank_start),
    .screen_x(screen_x), .rd_distance(rd_distance), .rd_uv_x(rd_uv_x), .swap_pending(swap_pending),
    .wr_error(wr_error), .frame_count(frame_count), .dropped_writes(dropped_writes)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic forget();
    for (int i = 0; i < SW; i++) begin
      disp[i].known = 1'b0;
      hid[i].known = 1'b0;
    end
  endtask
  task automatic step(input bit r, input bit wv, input logic [9:0] col, input logic [15:0] d,
                      input logic [UW-1:0] u, input bit fd, input bit vb, input logic [9:0] sx);
    bit ek;
    logic [15:0] ed;
    logic [UW-1:0] eu;
    ent_t t;
    reset = r; wr_valid = wv; wr_column = col; wr_distance = d; wr_uv_x = u;
    frame_done = fd; vblank_start = vb; screen_x = sx;
    if (r || !m_valid || sx >= SW) begin
      ek = 1'b1; ed = 16'hFFFF; eu = '0;
    end else begin
      ek = disp[sx].known; ed = disp[sx].d; eu = disp[sx].u;
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_pend = 0; m_err = 0; m_fc = 0; m_dw = 0;
      forget();
    end else begin
      if (wv && !m_pend) begin
        if (col < SW) hid[col] = '{1'b1, (d == 16'd0 ? 16'h0001 : d), u};
        else begin
          m_err = 1;
          if (m_dw != 16'hFFFF) m_dw++;
        end
      end
      if (vb && (m_pend || fd)) begin
        for (int i = 0; i < SW; i++) begin
          t = disp[i]; disp[i] = hid[i]; hid[i] = t;
        end
        m_valid = 1; m_pend = 0;
        if (m_fc != 16'hFFFF) m_fc++;
      end else if (fd) m_pend = 1;
    end
    if (ek) begin
      check("rd_distance", 32'(rd_distance), 32'(ed));
      check("rd_uv_x", 32'(rd_uv_x), 32'(eu));
    end
    check("wr_ready", 32'(wr_ready), 32'(!r && !m_pend));
    check("swap_pending", 32'(swap_pending), 32'(m_pend));
    check("wr_error", 32'(wr_error), 32'(m_err));
`ifdef COLUMN_BUFFER_STATS_EN
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("dropped_writes", 32'(dropped_writes), 32'(m_dw));
`else
    check("frame_count", 32'(frame_count), 32'd0);
    check("dropped_writes", 32'(dropped_writes), 32'd0);
`endif
  endtask
  initial begin
    forget();
    m_valid = 0; m_pend = 0; m_err = 0; m_fc = 0; m_dw = 0;
    reset = 1; wr_valid = 0; wr_column = 0; wr_distance = 0; wr_uv_x = 0;
    frame_done = 0; vblank_start = 0; screen_x = 0;
    tbl[0]  = '{1, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd5,   16'hFFFF, 6'd0,  0, 0};
    tbl[1]  = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd5,   16'hFFFF, 6'd0,  1, 0};
    tbl[2]  = '{0, 1, 10'd3,   16'h0280, 6'd17, 0, 0, 10'd3,   16'hFFFF, 6'd0,  1, 0};
    tbl[3]  = '{0, 1, 10'd7,   16'h0000, 6'd5,  1, 0, 10'd3,   16'hFFFF, 6'd0,  0, 1};
    tbl[4]  = '{0, 1, 10'd9,   16'h1234, 6'd1,  1, 0, 10'd3,   16'hFFFF, 6'd0,  0, 1};
    tbl[5]  = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 1, 10'd3,   16'hFFFF, 6'd0,  1, 0};
    tbl[6]  = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd3,   16'h0280, 6'd17, 1, 0};
    tbl[7]  = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd7,   16'h0001, 6'd5,  1, 0};
    tbl[8]  = '{0, 1, 10'd640, 16'h4444, 6'd3,  0, 0, 10'd700, 16'hFFFF, 6'd0,  1, 0};
    tbl[9]  = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd3,   16'h0280, 6'd17, 1, 0};
    tbl[10] = '{0, 1, 10'd3,   16'h0500, 6'd2,  1, 1, 10'd3,   16'h0280, 6'd17, 1, 0};
    tbl[11] = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd3,   16'h0500, 6'd2,  1, 0};
    tbl[12] = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 1, 10'd3,   16'h0500, 6'd2,  1, 0};
    tbl[13] = '{0, 1, 10'd3,   16'h0777, 6'd9,  0, 0, 10'd3,   16'h0500, 6'd2,  1, 0};
    tbl[14] = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd3,   16'h0500, 6'd2,  1, 0};
    tbl[15] = '{1, 1, 10'd3,   16'h0999, 6'd4,  1, 1, 10'd3,   16'hFFFF, 6'd0,  0, 0};
    tbl[16] = '{0, 0, 10'd0,   16'h0000, 6'd0,  0, 0, 10'd3,   16'hFFFF, 6'd0,  1, 0};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].wv, tbl[i].col, tbl[i].d, tbl[i].u, tbl[i].fd, tbl[i].vb, tbl[i].sx);
      check($sformatf("vec%0d rd_distance", i), 32'(rd_distance), 32'(tbl[i].ed));
      check($sformatf("vec%0d rd_uv_x", i), 32'(rd_uv_x), 32'(tbl[i].eu));
      check($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].er));
      check($sformatf("vec%0d swap_pending", i), 32'(swap_pending), 32'(tbl[i].ep));
    end
    step(1, 0, 10'd0, 16'd0, '0, 0, 0, 10'd0);
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 9) < 7,
           ($urandom_range(0, 19) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639)),
           ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom),
           UW'($urandom),
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 39) == 0,
           ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
